// File: rtl/fu_reservation_station.sv
// Collapsing-queue reservation station: oldest-first select, CDB wakeup and insert-time capture.
// Optional macro RS_CDB_BYPASS_EN lets a CDB match count toward readiness in its wakeup cycle.

package fu_rs_pkg;
  localparam int NUM_FU       = 2;
  localparam int NUM_PHYS_REG = 32;
  localparam int WORD_SIZE_P  = 32;
  localparam int TAG_W        = $clog2(NUM_PHYS_REG);

  typedef struct packed {
    logic [3:0]             op;
    logic [TAG_W-1:0]       dest_tag;
    logic [TAG_W-1:0]       source_1_tag;
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic                   source_1_v;
    logic [TAG_W-1:0]       source_2_tag;
    logic [WORD_SIZE_P-1:0] source_2_data;
    logic                   source_2_v;
  } issued_instruction_t;

  localparam int INSTR_W = $bits(issued_instruction_t);
endpackage

module fu_reservation_station
  import fu_rs_pkg::*;
#(
  parameter int rs_entries = 4,
  parameter int fu_id_p    = 0
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [INSTR_W-1:0]                  instruction_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [NUM_FU-1:0]                   cdb_valid_i,
  input  logic [NUM_FU-1:0][TAG_W-1:0]        cdb_tag_i,
  input  logic [NUM_FU-1:0][WORD_SIZE_P-1:0]  cdb_data_i,
  output logic [INSTR_W-1:0]                  instruction_o,
  output logic                                valid_o,
  input  logic                                fu_ready_i
);

  localparam int IDX_W = $clog2(rs_entries);
  localparam int CNT_W = $clog2(rs_entries + 1);

  if (rs_entries < 2 || rs_entries > 16 || (rs_entries & (rs_entries - 1)) != 0 ||
      fu_id_p < 0 || fu_id_p >= NUM_FU) begin : g_bad_cfg
    $error("fu_reservation_station: illegal rs_entries or fu_id_p");
  end

  issued_instruction_t       entry_q [rs_entries];
  issued_instruction_t       entry_d [rs_entries];
  logic [CNT_W-1:0]          count_q, count_d;

  // woken has one spare zero slot so the shift-down can always read index i+1.
  issued_instruction_t       woken [rs_entries+1];
  logic [rs_entries-1:0]     entry_valid;
  logic [rs_entries-1:0]     entry_ready;
  logic [IDX_W-1:0]          sel_idx;
  logic [CNT_W-1:0]          base_cnt;
  logic                      transfer;
  logic                      insert;

  // Ports are scanned high to low so the lowest-numbered matching port is written last and wins.
  function automatic issued_instruction_t capture(issued_instruction_t e);
    issued_instruction_t r = e;
    for (int p = NUM_FU - 1; p >= 0; p--) begin
      if (cdb_valid_i[p] && !e.source_1_v && cdb_tag_i[p] == e.source_1_tag) begin
        r.source_1_data = cdb_data_i[p];
        r.source_1_v    = 1'b1;
      end
      if (cdb_valid_i[p] && !e.source_2_v && cdb_tag_i[p] == e.source_2_tag) begin
        r.source_2_data = cdb_data_i[p];
        r.source_2_v    = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    woken[rs_entries] = '0;
    entry_valid       = '0;
    entry_ready       = '0;
    for (int i = 0; i < rs_entries; i++) begin
      woken[i]       = capture(entry_q[i]);
      entry_valid[i] = (CNT_W'(i) < count_q);
`ifdef RS_CDB_BYPASS_EN
      entry_ready[i] = entry_valid[i] & woken[i].source_1_v & woken[i].source_2_v;
`else
      entry_ready[i] = entry_valid[i] & entry_q[i].source_1_v & entry_q[i].source_2_v;
`endif
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = rs_entries - 1; i >= 0; i--) begin
      if (entry_ready[i]) sel_idx = IDX_W'(i);
    end
  end

  assign valid_o  = |entry_ready;
  assign ready_o  = (count_q != CNT_W'(rs_entries));
  assign transfer = valid_o & fu_ready_i;
  assign insert   = valid_i & ready_o;

  always_comb begin
    instruction_o = '0;
    if (valid_o) begin
`ifdef RS_CDB_BYPASS_EN
      instruction_o = woken[sel_idx];
`else
      instruction_o = entry_q[sel_idx];
`endif
    end
  end

  // Removal happens before insertion, so the new entry lands at count or count-1.
  always_comb begin
    base_cnt = count_q - CNT_W'(transfer);
    count_d  = base_cnt + CNT_W'(insert);
    for (int i = 0; i < rs_entries; i++) begin
      if (transfer && i >= int'(sel_idx)) entry_d[i] = woken[i+1];
      else                                entry_d[i] = woken[i];
      if (CNT_W'(i) >= count_d)                 entry_d[i] = '0;
      else if (insert && CNT_W'(i) == base_cnt) entry_d[i] = capture(issued_instruction_t'(instruction_i));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      // NOTE: the payload array is reset too, so free slots always read as zero.
      for (int i = 0; i < rs_entries; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < rs_entries; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_fu_reservation_station.sv
// Directed, table-driven bench for fu_reservation_station (default 4 entries, 2 CDB ports).
// Expectations follow RS_CDB_BYPASS_EN when the bench is built with that macro.

module tb_fu_reservation_station;
  import fu_rs_pkg::*;

`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [NUM_FU-1:0][TAG_W-1:0]       tags_t;
  typedef logic [NUM_FU-1:0][WORD_SIZE_P-1:0] data_t;

  typedef struct {
    logic                vld;
    issued_instruction_t ins;
    logic [NUM_FU-1:0]   cv;
    tags_t               ct;
    data_t               cd;
    logic                fr;
    logic                e_rdy;
    logic                e_vld;
    issued_instruction_t e_ins;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset_i = 1'b1;
  issued_instruction_t instruction_i = '0;
  logic                valid_i = 1'b0;
  logic                ready_o;
  logic [NUM_FU-1:0]   cdb_valid_i = '0;
  tags_t               cdb_tag_i = '0;
  data_t               cdb_data_i = '0;
  logic [INSTR_W-1:0]  instruction_o;
  logic                valid_o;
  logic                fu_ready_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  fu_reservation_station #(.rs_entries(4), .fu_id_p(0)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .instruction_i (instruction_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .cdb_valid_i   (cdb_valid_i),
    .cdb_tag_i     (cdb_tag_i),
    .cdb_data_i    (cdb_data_i),
    .instruction_o (instruction_o),
    .valid_o       (valid_o),
    .fu_ready_i    (fu_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic issued_instruction_t mk(input logic [4:0] dest,
      input logic [4:0] t1, input logic [31:0] d1, input logic v1,
      input logic [4:0] t2, input logic [31:0] d2, input logic v2);
    issued_instruction_t r;
    r.op = dest[3:0];
    r.dest_tag = dest;
    r.source_1_tag = t1; r.source_1_data = d1; r.source_1_v = v1;
    r.source_2_tag = t2; r.source_2_data = d2; r.source_2_v = v2;
    return r;
  endfunction

  function automatic vec_t V(input logic vld, input issued_instruction_t ins,
      input logic [NUM_FU-1:0] cv, input tags_t ct, input data_t cd, input logic fr,
      input logic e_rdy, input logic e_vld, input issued_instruction_t e_ins);
    vec_t v;
    v.vld = vld; v.ins = ins; v.cv = cv; v.ct = ct; v.cd = cd; v.fr = fr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_ins = e_ins;
    return v;
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic drive(input logic vld, input issued_instruction_t ins, input logic [NUM_FU-1:0] cv,
                       input tags_t ct, input data_t cd, input logic fr);
    @(negedge clk);
    valid_i = vld; instruction_i = ins; cdb_valid_i = cv;
    cdb_tag_i = ct; cdb_data_i = cd; fu_ready_i = fr;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_rdy, input logic e_vld,
                            input issued_instruction_t e_ins);
    check({tag, ".ready_o"},       128'(ready_o),       128'(e_rdy));
    check({tag, ".valid_o"},       128'(valid_o),       128'(e_vld));
    check({tag, ".instruction_o"}, 128'(instruction_o), 128'(e_ins));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    issued_instruction_t z, a, b1, b2, b3, b4, c, e0, e1, e1w, e2, f, fw;
    issued_instruction_t g, gw, h1, h2, h3, j;
    tags_t nt;
    data_t nd;
    vec_t vecs[25];

    z  = '0; nt = '0; nd = '0;
    a  = mk(5'd5,  5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1);
    b1 = mk(5'd1,  5'd0, 32'h101, 1'b1, 5'd0, 32'h201, 1'b1);
    b2 = mk(5'd2,  5'd0, 32'h102, 1'b1, 5'd0, 32'h202, 1'b1);
    b3 = mk(5'd3,  5'd0, 32'h103, 1'b1, 5'd0, 32'h203, 1'b1);
    b4 = mk(5'd4,  5'd0, 32'h104, 1'b1, 5'd0, 32'h204, 1'b1);
    c  = mk(5'd9,  5'd0, 32'h109, 1'b1, 5'd0, 32'h209, 1'b1);
    e0 = mk(5'd10, 5'd0, 32'h1,   1'b1, 5'd0, 32'h2,   1'b1);
    e1 = mk(5'd11, 5'd20, 32'h0,    1'b0, 5'd3, 32'h33, 1'b1);
    e1w= mk(5'd11, 5'd20, 32'h1234, 1'b1, 5'd3, 32'h33, 1'b1);
    e2 = mk(5'd12, 5'd0, 32'h5,   1'b1, 5'd0, 32'h6,   1'b1);
    f  = mk(5'd13, 5'd4, 32'h44, 1'b1, 5'd9, 32'h0,    1'b0);
    fw = mk(5'd13, 5'd4, 32'h44, 1'b1, 5'd9, 32'hAAAA, 1'b1);

    vecs[0]  = V(1, a,  2'b00, nt, nd, 0, 1, 0, z);
    vecs[1]  = V(0, z,  2'b00, nt, nd, 1, 1, 1, a);
    vecs[2]  = V(0, z,  2'b00, nt, nd, 0, 1, 0, z);
    vecs[3]  = V(1, b1, 2'b00, nt, nd, 0, 1, 0, z);
    vecs[4]  = V(1, b2, 2'b00, nt, nd, 0, 1, 1, b1);
    vecs[5]  = V(1, b3, 2'b00, nt, nd, 0, 1, 1, b1);
    vecs[6]  = V(1, b4, 2'b00, nt, nd, 0, 1, 1, b1);
    vecs[7]  = V(1, c,  2'b00, nt, nd, 0, 0, 1, b1);
    vecs[8]  = V(1, c,  2'b00, nt, nd, 1, 0, 1, b1);
    vecs[9]  = V(0, z,  2'b00, nt, nd, 0, 1, 1, b2);
    vecs[10] = V(0, z,  2'b00, nt, nd, 1, 1, 1, b2);
    vecs[11] = V(0, z,  2'b00, nt, nd, 1, 1, 1, b3);
    vecs[12] = V(0, z,  2'b00, nt, nd, 1, 1, 1, b4);
    vecs[13] = V(0, z,  2'b00, nt, nd, 0, 1, 0, z);
    vecs[14] = V(1, e0, 2'b00, nt, nd, 0, 1, 0, z);
    vecs[15] = V(1, e1, 2'b00, nt, nd, 0, 1, 1, e0);
    vecs[16] = V(1, e2, 2'b00, nt, nd, 0, 1, 1, e0);
    vecs[17] = V(0, z,  2'b00, nt, nd, 1, 1, 1, e0);
    vecs[18] = V(0, z,  2'b00, nt, nd, 1, 1, 1, e2);
    vecs[19] = V(0, z,  2'b01, {5'd0, 5'd20}, {32'h0, 32'h1234}, 0, 1, BYP, BYP ? e1w : z);
    vecs[20] = V(0, z,  2'b00, nt, nd, 1, 1, 1, e1w);
    vecs[21] = V(0, z,  2'b00, nt, nd, 0, 1, 0, z);
    vecs[22] = V(1, f,  2'b11, {5'd9, 5'd9}, {32'hBBBB, 32'hAAAA}, 0, 1, 0, z);
    vecs[23] = V(0, z,  2'b00, nt, nd, 1, 1, 1, fw);
    vecs[24] = V(0, z,  2'b00, nt, nd, 0, 1, 0, z);

    // Reset state, both while held and right after release.
    @(negedge clk); @(negedge clk);
    #1;
    expect_out("in_reset", 1'b1, 1'b0, z);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    expect_out("post_reset", 1'b1, 1'b0, z);

    for (int k = 0; k < 25; k++) begin
      drive(vecs[k].vld, vecs[k].ins, vecs[k].cv, vecs[k].ct, vecs[k].cd, vecs[k].fr);
      expect_out($sformatf("vec%0d", k), vecs[k].e_rdy, vecs[k].e_vld, vecs[k].e_ins);
    end

    // Wakeup from CDB port 1 two cycles after insert.
    g  = mk(5'd14, 5'd7, 32'h0,    1'b0, 5'd6, 32'h66, 1'b1);
    gw = mk(5'd14, 5'd7, 32'hBEEF, 1'b1, 5'd6, 32'h66, 1'b1);
    drive(1, g, 2'b00, nt, nd, 1);
    expect_out("wake_c0", 1'b1, 1'b0, z);
    drive(0, z, 2'b00, nt, nd, 1);
    expect_out("wake_c1", 1'b1, 1'b0, z);
    drive(0, z, 2'b10, {5'd7, 5'd0}, {32'hBEEF, 32'h0}, 1);
    expect_out("wake_c2", 1'b1, BYP, BYP ? gw : z);
    drive(0, z, 2'b00, nt, nd, 1);
    expect_out("wake_c3", 1'b1, !BYP, BYP ? z : gw);
    drive(0, z, 2'b00, nt, nd, 1);
    expect_out("wake_c4", 1'b1, 1'b0, z);

    // Asynchronous reset with three entries and a transfer pending.
    h1 = mk(5'd21, 5'd0, 32'h21, 1'b1, 5'd0, 32'h21, 1'b1);
    h2 = mk(5'd22, 5'd0, 32'h22, 1'b1, 5'd0, 32'h22, 1'b1);
    h3 = mk(5'd23, 5'd0, 32'h23, 1'b1, 5'd0, 32'h23, 1'b1);
    j  = mk(5'd24, 5'd0, 32'h24, 1'b1, 5'd0, 32'h24, 1'b1);
    drive(1, h1, 2'b00, nt, nd, 0);
    drive(1, h2, 2'b00, nt, nd, 0);
    drive(1, h3, 2'b00, nt, nd, 0);
    drive(0, z, 2'b00, nt, nd, 1);
    expect_out("pre_rst", 1'b1, 1'b1, h1);
    #2;
    reset_i = 1'b1;
    #1;
    expect_out("async_rst", 1'b1, 1'b0, z);
    @(negedge clk);
    reset_i = 1'b0;
    drive(0, z, 2'b00, nt, nd, 0);
    expect_out("after_rst", 1'b1, 1'b0, z);
    drive(1, j, 2'b00, nt, nd, 0);
    drive(0, z, 2'b00, nt, nd, 1);
    expect_out("after_rst_ins", 1'b1, 1'b1, j);
    drive(0, z, 2'b00, nt, nd, 0);
    expect_out("after_rst_empty", 1'b1, 1'b0, z);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
